// File: rtl/mont_pkg.sv
//------------------------------------------------------------------------------
// mont_pkg : shared Montgomery constants, FSM state type and counter sizing.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mont_pkg;

    localparam int MONT_W = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FAIL = 2'd2
    } mont_state_e;

    // Step counter must hold 2W-1; one spare bit keeps the width safe for any W.
    function automatic int mont_cnt_w(input int w);
        return $clog2(2 * w) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mont_dbl_mod.sv
//------------------------------------------------------------------------------
// mont_dbl_mod : combinational y = 2x mod p, valid when x < p.
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mont_dbl_mod #(
    parameter int W = 256
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] p,
    output logic [W-1:0] y
);

    logic [W:0] t;
    logic [W:0] p_ext;
    logic [W:0] res;
    logic       unused_msb;

    assign t     = {x, 1'b0};
    assign p_ext = {1'b0, p};
    // With x < p the reduced result is always below p, so its top bit is zero.
    assign res   = (t >= p_ext) ? (t - p_ext) : t;
    assign y     = res[W-1:0];
    assign unused_msb = res[W];

endmodule

`default_nettype wire

// File: rtl/mont_r2_precompute.sv
//------------------------------------------------------------------------------
// mont_r2_precompute : computes R^2 mod P (R = 2^W) by 2W doubling steps.
// Revision           : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mont_r2_precompute
    import mont_pkg::*;
#(
    parameter int W = MONT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] P,
    output logic [W-1:0] R2,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int            CW   = mont_cnt_w(W);
    localparam logic [CW-1:0] LAST = CW'(2 * W - 1);

    mont_state_e   state_q, state_d;
    logic [W-1:0]  p_q, p_d;
    logic [W-1:0]  x_q, x_d;
    logic [W-1:0]  r2_q, r2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [W-1:0]  x_dbl;
    logic          p_ok;

    mont_dbl_mod #(.W(W)) u_dbl (
        .x (x_q),
        .p (p_q),
        .y (x_dbl)
    );

    assign p_ok = P[0] && (P >= W'(3));

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        x_d     = x_q;
        r2_d    = r2_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    p_d     = P;
                    x_d     = W'(1);
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = p_ok ? RUN : FAIL;
                end
            end
            RUN: begin
                x_d   = x_dbl;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    r2_d    = x_dbl;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            FAIL: begin
                r2_d    = '0;
                err_d   = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            x_q     <= '0;
            r2_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            x_q     <= x_d;
            r2_q    <= r2_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign R2   = r2_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mont_r2_precompute.sv
//------------------------------------------------------------------------------
// tb_mont_r2_precompute : scoreboard bench for the R^2 mod P precompute block.
// Revision              : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mont_r2_precompute;

    localparam int NW = 8;
    localparam int WW = 256;

    typedef struct {
        logic [NW-1:0] r2;
        logic          err;
        int            due;
    } sb_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NW-1:0] P = '0;
    logic [NW-1:0] R2;
    logic          busy, done, err;

    logic          start_w = 1'b0;
    logic [WW-1:0] P_w = '0;
    logic [WW-1:0] R2_w;
    logic          busy_w, done_w, err_w;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  done_cnt = 0;
    sb_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mont_r2_precompute #(.W(NW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .P(P),
        .R2(R2), .busy(busy), .done(done), .err(err)
    );

    mont_r2_precompute #(.W(WW)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start_w), .P(P_w),
        .R2(R2_w), .busy(busy_w), .done(done_w), .err(err_w)
    );

    // Reference: 2^16 mod p for odd p >= 3, error otherwise.
    function automatic logic [NW-1:0] r2_model(input int p);
        if (p < 3 || (p % 2) == 0) return '0;
        return NW'(65536 % p);
    endfunction

    function automatic logic err_model(input int p);
        return (p < 3 || (p % 2) == 0);
    endfunction

    // Scoreboard monitor: every done pops one expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            sb_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no done", cyc);
            end else begin
                e = sb_q.pop_front();
                checks++;
                if (R2 !== e.r2) begin
                    errors++;
                    $display("FAIL r2_value: got %0d, required %0d", R2, e.r2);
                end
                checks++;
                if (err !== e.err) begin
                    errors++;
                    $display("FAIL err_flag: got %0b, required %0b", err, e.err);
                end
                checks++;
                if (cyc !== e.due) begin
                    errors++;
                    $display("FAIL done_latency: got cycle %0d, required cycle %0d", cyc, e.due);
                end
            end
        end
    end

    // Drives one start pulse at a negedge and records the expected completion.
    task automatic issue(input int p);
        sb_t e;
        int  lat;
        @(negedge clk);
        P     = NW'(p);
        start = 1'b1;
        lat   = err_model(p) ? 1 : 2 * NW;
        e.r2  = r2_model(p);
        e.err = err_model(p);
        e.due = cyc + 1 + lat;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got %0d pending results, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (R2 !== 8'd0) begin errors++; $display("FAIL reset_r2: got %0d, required 0", R2); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b, required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b, required 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b, required 0", err); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_valid();
        int plist[3] = '{13, 251, 255};
        foreach (plist[i]) begin
            issue(plist[i]);
            repeat (4) @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_during_run: P=%0d got %0b, required 1", plist[i], busy);
            end
            wait_drain("valid");
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_after_done: P=%0d got %0b, required 0", plist[i], busy);
            end
        end
    endtask

    task automatic test_wide();
        int n;
        int busy_bad = 0;
        @(negedge clk);
        P_w     = {WW{1'b1}} - WW'(188);
        start_w = 1'b1;
        n       = cyc;
        @(negedge clk);
        start_w = 1'b0;
        while (!done_w && cyc < n + 700) begin
            if (!busy_w) busy_bad++;
            @(negedge clk);
        end
        checks++;
        if (cyc - (n + 1) !== 2 * WW) begin
            errors++;
            $display("FAIL wide_latency: got %0d cycles, required %0d", cyc - (n + 1), 2 * WW);
        end
        checks++;
        if (R2_w !== WW'(35721)) begin
            errors++;
            $display("FAIL wide_r2: got 0x%0h, required 0x8b89", R2_w);
        end
        checks++;
        if (err_w !== 1'b0) begin errors++; $display("FAIL wide_err: got %0b, required 0", err_w); end
        checks++;
        if (busy_bad !== 0) begin errors++; $display("FAIL wide_busy: got %0d low cycles, required 0", busy_bad); end
        checks++;
        if (busy_w !== 1'b0) begin errors++; $display("FAIL wide_busy_at_done: got %0b, required 0", busy_w); end
    endtask

    task automatic test_invalid();
        issue(12);
        wait_drain("invalid12");
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_held: got %0b, required 1", err); end
        issue(1);
        wait_drain("invalid1");
        issue(13);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %0b, required 0", err); end
        wait_drain("after_invalid");
    endtask

    task automatic test_ignored();
        int d0 = done_cnt;
        issue(13);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        P     = 8'd11;
        wait_drain("ignored");
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL single_done: got %0d done pulses, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_reset_midrun();
        issue(13);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b, required 0", busy); end
        checks++; if (R2 !== 8'd0) begin errors++; $display("FAIL abort_r2: got %0d, required 0", R2); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %0b, required 0", done); end
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        issue(11);
        wait_drain("restart");
    endtask

    task automatic test_back_to_back();
        sb_t e;
        int  n;
        @(negedge clk);
        P     = 8'd13;
        start = 1'b1;
        n     = cyc;
        for (int i = 0; i < 3; i++) begin
            e.r2  = 8'd3;
            e.err = 1'b0;
            e.due = n + 1 + 2 * NW + i * (2 * NW + 1);
            sb_q.push_back(e);
        end
        repeat (3 * (2 * NW + 1)) @(negedge clk);
        start = 1'b0;
        wait_drain("back_to_back");
        repeat (20) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_valid();
        test_wide();
        test_invalid();
        test_ignored();
        test_reset_midrun();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
